pkt_buf_mslot: RTL

Multi-slot packet buffer that succeeds the single fixed-image packet RAM. It accepts packets word-by-word from the ingress stream into one of `SLOTS` fixed-size slots and exposes the oldest committed packet for random-access, word-addressed reads by the parser/pipeline. The head slot is freed by an explicit release. Width, slot depth, slot count and address-to-word mapping are parameters. Truncation and occupancy status are reported.

---
 rtl/pkt_buf_mslot_if.sv | 44 ++++
 rtl/pkt_buf_mslot.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pkt_buf_mslot_if.sv
// pkt_buf_mslot_if
// Bundles the ingress stream, head-packet read port, release strobe and
// status outputs of pkt_buf_mslot.
//   slave  : the buffer (consumes wr_*/rd_*/addr/release, drives status/data)
//   master : the producer/consumer side (testbench or pipeline)
// Handshake: an ingress word transfers on a rising clk edge where
// wr_valid_i & wr_ready_o are both high; wr_data_i/wr_last_i are only
// meaningful while wr_valid_i is high. wr_ready_o does not depend on
// wr_valid_i, so the producer may wait for ready before raising valid.
interface pkt_buf_mslot_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int SLOT_WORDS = 64,
  parameter int SLOTS      = 4
);
  localparam int LW = $clog2(SLOT_WORDS) + 1;
  localparam int CW = $clog2(SLOTS) + 1;

  logic                  wr_valid_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  wr_last_i;
  logic                  wr_ready_o;
  logic                  pkt_valid_o;
  logic [LW-1:0]         pkt_len_o;
  logic                  pkt_trunc_o;
  logic                  rd_en_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  release_i;
  logic [CW-1:0]         pkt_cnt_o;
  logic [15:0]           trunc_cnt_o;

  modport slave (
    input  wr_valid_i, wr_data_i, wr_last_i, rd_en_i, addr_i, release_i,
    output wr_ready_o, pkt_valid_o, pkt_len_o, pkt_trunc_o, data_o,
           pkt_cnt_o, trunc_cnt_o
  );

  modport master (
    output wr_valid_i, wr_data_i, wr_last_i, rd_en_i, addr_i, release_i,
    input  wr_ready_o, pkt_valid_o, pkt_len_o, pkt_trunc_o, data_o,
           pkt_cnt_o, trunc_cnt_o
  );
endinterface

// File: rtl/pkt_buf_mslot.sv
// pkt_buf_mslot
// Multi-slot packet buffer. Ingress words fill the tail slot; wr_last_i
// commits the slot. The oldest committed packet (head) is exposed for
// word-addressed reads with one cycle of latency and is freed by release_i.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : pkt_buf_mslot_if.slave (ingress stream, read port, release,
//          head length/trunc status, packet and truncation counters)
module pkt_buf_mslot #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int ADDR_SHIFT = 2,
  parameter int SLOT_WORDS = 64,
  parameter int SLOTS      = 4
) (
  input  logic            clk,
  input  logic            rst,
  pkt_buf_mslot_if.slave  bus
);
  localparam int WI = $clog2(SLOT_WORDS);
  localparam int SI = $clog2(SLOTS);
  localparam int LW = WI + 1;
  localparam int CW = SI + 1;

  // Flat storage: slot number in the upper index bits, word in the lower.
  logic [DATA_WIDTH-1:0] mem [SLOTS*SLOT_WORDS];

  logic [SI-1:0]         head, tail;
  logic [CW-1:0]         cnt;
  logic [LW-1:0]         wptr;
  logic                  cur_trunc;
  logic [LW-1:0]         len_q   [SLOTS];
  logic                  trunc_q [SLOTS];
  logic [DATA_WIDTH-1:0] rd_data;
  logic [15:0]           trunc_cnt;

  logic          wr_ready, pkt_valid, wr_fire, commit, rel_fire, in_room;
  logic          commit_trunc;
  logic [LW-1:0] commit_len;
  logic [WI-1:0] rd_idx;

  always_comb begin
    wr_ready     = (cnt != CW'(SLOTS));
    pkt_valid    = (cnt != '0);
    wr_fire      = bus.wr_valid_i & wr_ready;
    commit       = wr_fire & bus.wr_last_i;
    rel_fire     = bus.release_i & pkt_valid;
    // wptr saturates at SLOT_WORDS; at that point further words are dropped.
    in_room      = (wptr != LW'(SLOT_WORDS));
    commit_len   = in_room ? (wptr + 1'b1) : LW'(SLOT_WORDS);
    commit_trunc = cur_trunc | ~in_room;
    rd_idx       = bus.addr_i[ADDR_SHIFT +: WI];
  end

  // Memory write port: no reset, contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire && in_room) begin
      mem[{tail, wptr[WI-1:0]}] <= bus.wr_data_i;
    end
  end

  // Registered read port. Reads past the head packet's length return zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (bus.rd_en_i) begin
      if (pkt_valid && ({1'b0, rd_idx} < len_q[head])) begin
        rd_data <= mem[{head, rd_idx}];
      end else begin
        rd_data <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      wptr      <= '0;
      cur_trunc <= 1'b0;
      trunc_cnt <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        len_q[i]   <= '0;
        trunc_q[i] <= 1'b0;
      end
    end else begin
      if (wr_fire) begin
        if (commit) begin
          len_q[tail]   <= commit_len;
          trunc_q[tail] <= commit_trunc;
          tail          <= tail + 1'b1;
          wptr          <= '0;
          cur_trunc     <= 1'b0;
          if (commit_trunc && (trunc_cnt != 16'hFFFF)) begin
            trunc_cnt <= trunc_cnt + 1'b1;
          end
        end else if (in_room) begin
          wptr <= wptr + 1'b1;
        end else begin
          cur_trunc <= 1'b1;
        end
      end
      if (rel_fire) begin
        head <= head + 1'b1;
      end
      // Commit and release together leave the count unchanged.
      case ({commit, rel_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    bus.wr_ready_o  = wr_ready;
    bus.pkt_valid_o = pkt_valid;
    bus.pkt_len_o   = pkt_valid ? len_q[head] : '0;
    bus.pkt_trunc_o = pkt_valid ? trunc_q[head] : 1'b0;
    bus.data_o      = rd_data;
    bus.pkt_cnt_o   = cnt;
    bus.trunc_cnt_o = trunc_cnt;
  end
endmodule
